// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder.
//   state_t : FSM state encoding (2'd3 is unused and recovers to IDLE)
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_adder_full_adder.sv
// One-bit gate-level full adder used as the serial bit cell.
// Ports:
//   a, b, c : operand bits and carry-in
//   sum     : a ^ b ^ c
//   carry   : carry-out
module full_adder (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic sum,
  output logic carry
);

  logic w_axb;

  assign w_axb = a ^ b;
  assign sum   = w_axb ^ c;
  assign carry = (a & b) | (c & w_axb);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: captures two operands and a carry-in, then
// adds one bit pair per clock, LSB first, through a single full_adder cell.
// Ports:
//   clk, rst_n        : clock, async active-low reset
//   start             : load request, honoured only in IDLE
//   a_in, b_in, cin   : operands and carry-in, captured on accepted start
//   busy              : high while in RUN
//   done              : one-cycle pulse, sum_out/cout valid
//   sum_out, cout     : registered result, held until the next result
//
// state | meaning
// IDLE  | waiting for start
// RUN   | one bit pair summed per cycle, WIDTH cycles
// DONE  | result presented, done pulsed for one cycle
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum_out,
  output logic             cout
);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [WIDTH-1:0]   r_a_sh;
  logic [WIDTH-1:0]   r_b_sh;
  logic [WIDTH-1:0]   r_s_sh;
  logic               r_c;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_sum_out;
  logic               r_cout;
  logic               w_sum;
  logic               w_carry;
  logic               w_last;
  logic [WIDTH-1:0]   w_s_next;

  full_adder u_fa (
    .a     (r_a_sh[0]),
    .b     (r_b_sh[0]),
    .c     (r_c),
    .sum   (w_sum),
    .carry (w_carry)
  );

  assign w_last   = (r_cnt == CNT_W'(WIDTH - 1));
  assign w_s_next = {w_sum, r_s_sh[WIDTH-1:1]};

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (start) w_state_nxt = RUN;
      RUN:     if (w_last) w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_a_sh    <= '0;
      r_b_sh    <= '0;
      r_s_sh    <= '0;
      r_c       <= 1'b0;
      r_cnt     <= '0;
      r_sum_out <= '0;
      r_cout    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_a_sh <= a_in;
            r_b_sh <= b_in;
            r_c    <= cin;
            r_cnt  <= '0;
          end
        end
        RUN: begin
          r_c    <= w_carry;
          r_s_sh <= w_s_next;
          r_a_sh <= {1'b0, r_a_sh[WIDTH-1:1]};
          r_b_sh <= {1'b0, r_b_sh[WIDTH-1:1]};
          r_cnt  <= r_cnt + CNT_W'(1);
          // Output regs load on the edge entering DONE so the result is
          // already valid in the cycle done is high.
          if (w_last) begin
            r_sum_out <= w_s_next;
            r_cout    <= w_carry;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy    = (r_state == RUN);
  assign done    = (r_state == DONE);
  assign sum_out = r_sum_out;
  assign cout    = r_cout;

endmodule

// File: tb/tb_serial_adder.sv
module tb_serial_adder;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] sum_out;
  logic         cout;

  int n_cmp  = 0;
  int n_fail = 0;
  int done_cnt = 0;

  serial_adder #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .a_in    (a_in),
    .b_in    (b_in),
    .cin     (cin),
    .busy    (busy),
    .done    (done),
    .sum_out (sum_out),
    .cout    (cout)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (done === 1'b1) done_cnt++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain arithmetic, {cout,sum} = a + b + cin.
  function automatic logic [W:0] ref_add(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic c);
    return {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
  endfunction

  // One add from IDLE; optionally pokes start with new operands mid-RUN.
  task automatic do_add(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                        input bit poke, input string tag);
    logic [W:0] exp;
    int cyc;
    int d0;
    exp = ref_add(a, b, c);
    @(negedge clk);
    a_in = a; b_in = b; cin = c; start = 1'b1;
    @(negedge clk);
    #1 d0 = done_cnt;
    start = 1'b0;
    a_in = W'($urandom); b_in = W'($urandom); cin = 1'($urandom);
    cyc = 1;
    check({tag, "_busy"}, 32'(busy), 32'd1);
    while (done !== 1'b1 && cyc < 3 * W) begin
      @(negedge clk);
      cyc++;
      if (poke && cyc == 3) begin
        start = 1'b1; a_in = W'($urandom); b_in = W'($urandom); cin = 1'($urandom);
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    check({tag, "_latency"}, 32'(cyc), 32'(W + 1));
    check({tag, "_sum"}, 32'(sum_out), 32'(exp[W-1:0]));
    check({tag, "_cout"}, 32'(cout), 32'(exp[W]));
    @(negedge clk);
    check({tag, "_done_pulse"}, 32'(done), 32'd0);
    check({tag, "_sum_hold"}, 32'(sum_out), 32'(exp[W-1:0]));
    #1 check({tag, "_done_count"}, 32'(done_cnt - d0), 32'd1);
  endtask

  initial begin
    logic [W:0] exp_q[$];
    logic [W:0] e;
    int d0;
    int ph;

    rst_n = 1'b0; start = 1'b1;
    a_in = W'($urandom); b_in = W'($urandom); cin = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_sum", 32'(sum_out), 32'd0);
    check("rst_cout", 32'(cout), 32'd0);
    start = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_busy", 32'(busy), 32'd0);

    do_add(8'h3C, 8'h45, 1'b0, 1'b0, "add_3c_45");
    do_add(8'hFF, 8'h01, 1'b1, 1'b0, "ripple");
    do_add(8'h00, 8'h00, 1'b0, 1'b0, "zero");
    do_add(8'hFF, 8'hFF, 1'b1, 1'b0, "max");
    do_add(8'hA5, 8'h5A, 1'b0, 1'b1, "mid_run_start");

    // Abort at RUN cycle 4, then a clean add must follow.
    @(negedge clk);
    a_in = 8'hF0; b_in = 8'h0F; cin = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_sum", 32'(sum_out), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 d0 = done_cnt;
    repeat (W + 3) @(negedge clk);
    #1 check("abort_no_stale_done", 32'(done_cnt - d0), 32'd0);
    do_add(8'h10, 8'h20, 1'b0, 1'b0, "after_abort");

    // Back-to-back: start held high, new accept every W+2 cycles.
    @(negedge clk);
    for (int i = 0; i < 1000 * (W + 2); i++) begin
      if (i != 0) @(negedge clk);
      ph = i % (W + 2);
      if (ph == W + 1) begin
        check("b2b_done", 32'(done), 32'd1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("b2b_sum", 32'(sum_out), 32'(e[W-1:0]));
          check("b2b_cout", 32'(cout), 32'(e[W]));
        end else begin
          check("b2b_queue_empty", 32'd1, 32'd0);
        end
      end else begin
        check("b2b_no_done", 32'(done), 32'd0);
      end
      start = 1'b1;
      a_in = W'($urandom); b_in = W'($urandom); cin = 1'($urandom);
      if (ph == 0) exp_q.push_back(ref_add(a_in, b_in, cin));
    end
    @(negedge clk);
    start = 1'b0;
    repeat (W + 3) @(negedge clk);
    check("b2b_leftover", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
